// File: rtl/board_view_ctrl.sv
// Board orientation owner: schedules delayed/manual flips and arbitrates a shared
// coordinate-translation unit between the cursor (0) and renderer (1) paths.
module board_view_ctrl #(
   parameter int unsigned FLIP_DELAY = 8,
   parameter int unsigned CNT_W      = (FLIP_DELAY > 0) ? $clog2(FLIP_DELAY + 1) : 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       move_done_i,
   input  logic       auto_flip_en_i,
   input  logic       manual_flip_i,
   input  logic [1:0] req_i,
   input  logic [2:0] req_x0_i,
   input  logic [2:0] req_y0_i,
   input  logic [2:0] req_x1_i,
   input  logic [2:0] req_y1_i,
   output logic [1:0] gnt_o,
   output logic       rsp_valid_o,
   output logic       rsp_id_o,
   output logic [2:0] rsp_x_o,
   output logic [2:0] rsp_y_o,
   output logic       flipped_o,
   output logic       flip_pending_o
);

   typedef enum logic [1:0] {StIdle, StHold, StFlip} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flipped_q, flipped_d;
   logic             rr_q, rr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [2:0]       rsp_x_q, rsp_x_d;
   logic [2:0]       rsp_y_q, rsp_y_d;
   logic [1:0]       gnt;
   logic [2:0]       sel_x, sel_y;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      flipped_d = flipped_q;
      unique case (state_q)
         StIdle: begin
            // manual_flip takes priority so a coincident move_done yields one toggle, no hold
            if (manual_flip_i) begin
               state_d = StFlip;
            end else if (move_done_i && auto_flip_en_i) begin
               if (FLIP_DELAY == 0) begin
                  state_d = StFlip;
               end else begin
                  state_d = StHold;
                  cnt_d   = CNT_W'(FLIP_DELAY - 1);
               end
            end
         end
         StHold: begin
            if (manual_flip_i || (cnt_q == '0)) begin
               state_d = StFlip;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StFlip: begin
            flipped_d = ~flipped_q;
            cnt_d     = '0;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // No grants during the flip cycle so no response straddles an orientation change
   always_comb begin
      gnt = 2'b00;
      if (state_q != StFlip) begin
         unique case (req_i)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   always_comb begin
      sel_x       = gnt[1] ? req_x1_i : req_x0_i;
      sel_y       = gnt[1] ? req_y1_i : req_y0_i;
      rr_d        = rr_q;
      rsp_valid_d = |gnt;
      rsp_id_d    = rsp_id_q;
      rsp_x_d     = rsp_x_q;
      rsp_y_d     = rsp_y_q;
      if (|gnt) begin
         rr_d     = gnt[0];
         rsp_id_d = gnt[1];
         rsp_x_d  = flipped_q ? ~sel_x : sel_x;
         rsp_y_d  = flipped_q ? ~sel_y : sel_y;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         flipped_q   <= 1'b0;
         rr_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_x_q     <= 3'd0;
         rsp_y_q     <= 3'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flipped_q   <= flipped_d;
         rr_q        <= rr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_x_q     <= rsp_x_d;
         rsp_y_q     <= rsp_y_d;
      end
   end

   assign gnt_o          = gnt;
   assign rsp_valid_o    = rsp_valid_q;
   assign rsp_id_o       = rsp_id_q;
   assign rsp_x_o        = rsp_x_q;
   assign rsp_y_o        = rsp_y_q;
   assign flipped_o      = flipped_q;
   assign flip_pending_o = (state_q != StIdle);

endmodule
